multdiv_unit: RTL and testbench

Iterative signed multiply/divide unit in the execute stage, alongside the ALU. It consumes the A/B operands from the DX latch when the decoded ALU opcode is MUL or DIV. It stalls the front of the pipeline while it works, then presents a one-word result and exception flag for the XM latch to capture. Multiply uses shift-add Booth recoding; divide uses non-restoring division. Both are one step per cycle.

---
 rtl/multdiv_pkg.sv | 28 ++
 rtl/multdiv_booth_recoder.sv | 31 +++
 rtl/multdiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULTDIV_RADIX4_EN selects radix-4 Booth multiply (WIDTH/2 steps) instead of radix-2 (WIDTH steps).
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT) + 1;

    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    localparam logic [WIDTH_DEFAULT-1:0] INT_MIN = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};

`ifdef MULTDIV_RADIX4_EN
    localparam int BOOTH_BITS  = 3;
    localparam int BOOTH_SHIFT = 2;
`else
    localparam int BOOTH_BITS  = 2;
    localparam int BOOTH_SHIFT = 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_booth_recoder.sv
// Combinational Booth recoder: multiplier bit window to signed partial-product digit.
// Radix-4 window {b(i+1), b(i), b(i-1)} when MULTDIV_RADIX4_EN is defined, else radix-2 {b(i), b(i-1)}.
module booth_recoder
    import multdiv_pkg::*;
(
    input  logic [BOOTH_BITS-1:0] window,
    output logic signed [2:0]     digit
);

    // Digit = -2*b(i+1) + b(i) + b(i-1) for radix-4, b(i-1) - b(i) for radix-2
    always_comb begin
        digit = 3'sd0;
`ifdef MULTDIV_RADIX4_EN
        case (window)
            3'b000, 3'b111: digit = 3'sd0;
            3'b001, 3'b010: digit = 3'sd1;
            3'b011:         digit = 3'sd2;
            3'b100:         digit = 3'sb110;
            3'b101, 3'b110: digit = 3'sb111;
            default:        digit = 3'sd0;
        endcase
`else
        case (window)
            2'b01:   digit = 3'sd1;
            2'b10:   digit = 3'sb111;
            default: digit = 3'sd0;
        endcase
`endif
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (Booth) / divide (non-restoring) unit, one step per cycle.
// MULTDIV_RADIX4_EN halves multiply latency via radix-4 Booth; divide is unaffected.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam int              HW      = WIDTH + 2;
    localparam logic [CW-1:0]   N_MUL   = CW'(WIDTH / BOOTH_SHIFT);
    localparam logic [CW-1:0]   N_DIV   = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [HW-1:0]    hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             qm1_r;
    logic [WIDTH-1:0] opb_r;
    logic             neg_r;
    logic             div_zero_r;
    logic             div_ovf_r;

    logic [BOOTH_BITS-1:0] window_s;
    logic signed [2:0]     digit_s;
    logic [HW-1:0]         mcand_s;
    logic [HW-1:0]         addend_s;
    logic [HW-1:0]         acc_s;
    logic [HW+WIDTH:0]     mul_shift_s;
    logic [HW-1:0]         mul_hi_s;
    logic [WIDTH-1:0]      mul_lo_s;
    logic                  mul_qm1_s;
    logic                  mul_exc_s;

    logic [HW-1:0]         dvsr_s;
    logic [HW-1:0]         rem_sh_s;
    logic [HW-1:0]         rem_new_s;
    logic [WIDTH-1:0]      quot_new_s;
    logic [WIDTH-1:0]      div_result_s;
    logic                  div_exc_s;

    logic [WIDTH-1:0]      abs_a_s;
    logic [WIDTH-1:0]      abs_b_s;

    // During MUL, lo_r holds the multiplier being shifted out and qm1_r the bit below it
    assign window_s = {lo_r[BOOTH_BITS-2:0], qm1_r};

    booth_recoder u_booth_recoder (
        .window (window_s),
        .digit  (digit_s)
    );

    assign mcand_s = {{2{opb_r[WIDTH-1]}}, opb_r};
    assign dvsr_s  = {2'b00, opb_r};

    // Booth partial-product selection from the recoded digit
    always_comb begin
        addend_s = {HW{1'b0}};
        case (digit_s)
            3'sd1:   addend_s = mcand_s;
            3'sd2:   addend_s = mcand_s << 1;
            3'sb111: addend_s = -mcand_s;
            3'sb110: addend_s = -(mcand_s << 1);
            default: addend_s = {HW{1'b0}};
        endcase
    end

    // Accumulate then arithmetic-shift the whole {acc, multiplier, q-1} chain
    assign acc_s       = hi_r + addend_s;
    assign mul_shift_s = $signed({acc_s, lo_r, qm1_r}) >>> BOOTH_SHIFT;
    assign mul_hi_s    = mul_shift_s[HW+WIDTH:WIDTH+1];
    assign mul_lo_s    = mul_shift_s[WIDTH:1];
    assign mul_qm1_s   = mul_shift_s[0];
    assign mul_exc_s   = ~((&{mul_hi_s[WIDTH-1:0], mul_lo_s[WIDTH-1]}) |
                           (~|{mul_hi_s[WIDTH-1:0], mul_lo_s[WIDTH-1]}));

    // Non-restoring step: partial remainder in hi_r, dividend/quotient share lo_r
    assign rem_sh_s = {hi_r[HW-2:0], lo_r[WIDTH-1]};

    always_comb begin
        if (hi_r[HW-1]) begin
            rem_new_s = rem_sh_s + dvsr_s;
        end else begin
            rem_new_s = rem_sh_s - dvsr_s;
        end
    end

    assign quot_new_s = {lo_r[WIDTH-2:0], ~rem_new_s[HW-1]};

    // Special divide cases override the iterated quotient
    always_comb begin
        if (div_zero_r) begin
            div_result_s = {WIDTH{1'b0}};
            div_exc_s    = 1'b1;
        end else if (div_ovf_r) begin
            div_result_s = MIN_VAL;
            div_exc_s    = 1'b1;
        end else if (neg_r) begin
            div_result_s = -quot_new_s;
            div_exc_s    = 1'b0;
        end else begin
            div_result_s = quot_new_s;
            div_exc_s    = 1'b0;
        end
    end

    assign abs_a_s = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b_s = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= {CW{1'b0}};
            hi_r           <= {HW{1'b0}};
            lo_r           <= {WIDTH{1'b0}};
            qm1_r          <= 1'b0;
            opb_r          <= {WIDTH{1'b0}};
            neg_r          <= 1'b0;
            div_zero_r     <= 1'b0;
            div_ovf_r      <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        state_r <= MUL;
                        busy    <= 1'b1;
                        cnt_r   <= N_MUL;
                        hi_r    <= {HW{1'b0}};
                        lo_r    <= data_operandB;
                        qm1_r   <= 1'b0;
                        opb_r   <= data_operandA;
                    end else if (ctrl_DIV) begin
                        state_r    <= DIV;
                        busy       <= 1'b1;
                        cnt_r      <= N_DIV;
                        hi_r       <= {HW{1'b0}};
                        lo_r       <= abs_a_s;
                        qm1_r      <= 1'b0;
                        opb_r      <= abs_b_s;
                        neg_r      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero_r <= (data_operandB == {WIDTH{1'b0}});
                        div_ovf_r  <= (data_operandA == MIN_VAL) &&
                                      (data_operandB == {WIDTH{1'b1}});
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    hi_r  <= mul_hi_s;
                    lo_r  <= mul_lo_s;
                    qm1_r <= mul_qm1_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r        <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= mul_lo_s;
                        data_exception <= mul_exc_s;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DIV: begin
                    hi_r  <= rem_new_s;
                    lo_r  <= quot_new_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r        <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= div_result_s;
                        data_exception <= div_exc_s;
                    end else begin
                        state_r <= DIV;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vectors, handshake timing and random ops
// against an arithmetic reference model. Honours MULTDIV_RADIX4_EN for multiply latency.
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
    localparam int N_MUL = 16;
`else
    localparam int N_MUL = 32;
`endif
    localparam int N_DIV = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] MUL_A [5] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    localparam logic [31:0] MUL_B [5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] MUL_R [5] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd1};
    localparam logic        MUL_E [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    localparam logic [31:0] DIV_A [7] = '{32'hFFFF_FFEC, 32'd20, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    localparam logic [31:0] DIV_B [7] = '{32'd6, 32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd7, 32'hFFFF_FFFE};
    localparam logic [31:0] DIV_R [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd3};
    localparam logic        DIV_E [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clock = ~clock;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        r = p[31:0];
        e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    // Issue one operation and observe cycles t+1 .. t+n+3 (no comparisons here)
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int n, output logic [31:0] res, output logic exc, output int rdy_at,
                         output int rdy_cnt, output int busy_bad, output logic [31:0] res_end);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        rdy_at = -1;
        rdy_cnt = 0;
        busy_bad = 0;
        res = 'x;
        exc = 1'bx;
        for (int i = 1; i <= n + 3; i++) begin
            @(negedge clock);
            if (busy !== (i <= n)) busy_bad++;
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at = i;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
        res_end = data_result;
    endtask

    task automatic test_reset();
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got result=%h exc=%b rdy=%b busy=%b expected all zero",
                     data_result, data_exception, data_resultRDY, busy);
        end
    endtask

    task automatic test_mul_vectors();
        logic [31:0] res;
        logic [31:0] res_end;
        logic        exc;
        int          rdy_at;
        int          rdy_cnt;
        int          busy_bad;
        for (int k = 0; k < 5; k++) begin
            do_op(1'b1, 1'b0, MUL_A[k], MUL_B[k], N_MUL, res, exc, rdy_at, rdy_cnt, busy_bad, res_end);
            checks += 4;
            if (res !== MUL_R[k] || exc !== MUL_E[k]) begin
                errors++;
                $display("FAIL mul_vec%0d: got %h/%b expected %h/%b", k, res, exc, MUL_R[k], MUL_E[k]);
            end
            if (rdy_at != N_MUL + 1 || rdy_cnt != 1) begin
                errors++;
                $display("FAIL mul_rdy%0d: got at=%0d count=%0d expected at=%0d count=1", k, rdy_at, rdy_cnt, N_MUL + 1);
            end
            if (busy_bad != 0) begin
                errors++;
                $display("FAIL mul_busy%0d: got %0d bad cycles expected 0", k, busy_bad);
            end
            if (res_end !== MUL_R[k]) begin
                errors++;
                $display("FAIL mul_hold%0d: got %h expected %h", k, res_end, MUL_R[k]);
            end
        end
    endtask

    task automatic test_div_vectors();
        logic [31:0] res;
        logic [31:0] res_end;
        logic        exc;
        int          rdy_at;
        int          rdy_cnt;
        int          busy_bad;
        for (int k = 0; k < 7; k++) begin
            do_op(1'b0, 1'b1, DIV_A[k], DIV_B[k], N_DIV, res, exc, rdy_at, rdy_cnt, busy_bad, res_end);
            checks += 3;
            if (res !== DIV_R[k] || exc !== DIV_E[k]) begin
                errors++;
                $display("FAIL div_vec%0d: got %h/%b expected %h/%b", k, res, exc, DIV_R[k], DIV_E[k]);
            end
            if (rdy_at != N_DIV + 1 || rdy_cnt != 1) begin
                errors++;
                $display("FAIL div_rdy%0d: got at=%0d count=%0d expected at=%0d count=1", k, rdy_at, rdy_cnt, N_DIV + 1);
            end
            if (busy_bad != 0) begin
                errors++;
                $display("FAIL div_busy%0d: got %0d bad cycles expected 0", k, busy_bad);
            end
        end
    endtask

    task automatic test_collision();
        int          rdy_at = -1;
        int          rdy_cnt = 0;
        logic [31:0] res = 'x;
        logic        exc = 1'bx;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd6;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        for (int i = 1; i <= 2 * N_DIV + 10; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at = i;
                    res = data_result;
                    exc = data_exception;
                end
            end
            // a divide request while busy must be ignored
            ctrl_DIV = (i == 5);
            data_operandA = 32'd100;
            data_operandB = 32'd3;
        end
        checks += 2;
        if (res !== 32'd24 || exc !== 1'b0) begin
            errors++;
            $display("FAIL collision_result: got %h/%b expected 00000018/0", res, exc);
        end
        if (rdy_at != N_MUL + 1 || rdy_cnt != 1) begin
            errors++;
            $display("FAIL collision_rdy: got at=%0d count=%0d expected at=%0d count=1", rdy_at, rdy_cnt, N_MUL + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic        seen = 1'b0;
        int          rdy_at = -1;
        int          rdy_cnt = 0;
        logic [31:0] res = 'x;
        logic        exc = 1'bx;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'hFFFF_FFFB;
        data_operandB = 32'd9;
        @(posedge clock);
        #1 ctrl_MULT = 1'b0;
        for (int i = 1; i <= N_MUL + 3 && !seen; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || data_result !== 32'hFFFF_FFD3) begin
            errors++;
            $display("FAIL b2b_first: got seen=%b result=%h expected seen=1 result=ffffffd3", seen, data_result);
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'hFFFF_FFF9;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        for (int i = 1; i <= N_DIV + 3; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at = i;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
        checks += 2;
        if (res !== 32'hFFFF_FF72 || exc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b expected ffffff72/0", res, exc);
        end
        if (rdy_at != N_DIV + 1 || rdy_cnt != 1) begin
            errors++;
            $display("FAIL b2b_rdy: got at=%0d count=%0d expected at=%0d count=1", rdy_at, rdy_cnt, N_DIV + 1);
        end
    endtask

    task automatic test_reset_midop();
        int          rdy_cnt = 0;
        logic [31:0] res;
        logic [31:0] res_end;
        logic        exc;
        int          rdy_at;
        int          busy_bad;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1 ctrl_DIV = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            errors++;
            $display("FAIL midop_reset: got result=%h exc=%b rdy=%b busy=%b expected all zero",
                     data_result, data_exception, data_resultRDY, busy);
        end
        for (int i = 12; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_cnt++;
        end
        checks++;
        if (rdy_cnt != 0) begin
            errors++;
            $display("FAIL midop_quiet: got %0d active cycles expected 0", rdy_cnt);
        end
        do_op(1'b1, 1'b0, 32'd3, 32'd4, N_MUL, res, exc, rdy_at, rdy_cnt, busy_bad, res_end);
        checks++;
        if (res !== 32'd12 || exc !== 1'b0 || rdy_at != N_MUL + 1) begin
            errors++;
            $display("FAIL midop_after: got %h/%b at=%0d expected 0000000c/0 at=%0d", res, exc, rdy_at, N_MUL + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] res_end;
        logic [31:0] exp_r;
        logic        exp_e;
        logic        exc;
        logic        is_mul;
        int          rdy_at;
        int          rdy_cnt;
        int          busy_bad;
        int          n;
        for (int k = 0; k < 60; k++) begin
            is_mul = k[0];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(0, 200) - 100;
                3: a = $urandom_range(0, 70000) - 35000;
                default: ;
            endcase
            if (is_mul) begin
                model_mul(a, b, exp_r, exp_e);
                n = N_MUL;
            end else begin
                model_div(a, b, exp_r, exp_e);
                n = N_DIV;
            end
            do_op(is_mul, !is_mul, a, b, n, res, exc, rdy_at, rdy_cnt, busy_bad, res_end);
            checks += 2;
            if (res !== exp_r || exc !== exp_e) begin
                errors++;
                $display("FAIL rand_%s a=%h b=%h: got %h/%b expected %h/%b",
                         is_mul ? "mul" : "div", a, b, res, exc, exp_r, exp_e);
            end
            if (rdy_at != n + 1 || rdy_cnt != 1 || busy_bad != 0) begin
                errors++;
                $display("FAIL rand_timing: got at=%0d count=%0d busy_bad=%0d expected at=%0d count=1 busy_bad=0",
                         rdy_at, rdy_cnt, busy_bad, n + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_vectors();
        test_div_vectors();
        test_collision();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
